full_adder: RTL and testbench

- Ripple-carry adder with a combinational (zero-latency) result path and a registered copy of the result.
- Default build is a 1-bit full adder: sum = a ^ b ^ cin, cout = majority(a, b, cin).
- Used as a leaf arithmetic block and as a bring-up vehicle for the simulation and waveform flow.
- Also keeps a saturating count of clock cycles in which a carry-out occurred, for debug visibility.

---
 rtl/adder_pkg.sv | 11 +
 rtl/full_adder_if.sv | 28 ++
 rtl/full_adder_cell.sv | 15 +
 rtl/full_adder.sv | 52 +++++
 tb/tb_full_adder.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared defaults and the carry helper used by the ripple adder.
package adder_pkg;

   localparam int DEFAULT_WIDTH = 1;
   localparam int DEFAULT_CNT_W = 16;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; the adder sits on the slave side.
interface full_adder_if
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) ();

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic [CNT_W-1:0] carry_cnt;

   modport master (
      output a, b, cin,
      input  sum, cout, sum_q, cout_q, carry_cnt
   );

   modport slave (
      input  a, b, cin,
      output sum, cout, sum_q, cout_q, carry_cnt
   );

endinterface

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder cell.
module full_adder_cell
   import adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = maj3(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with a zero-latency result, a registered copy of it,
// and a saturating count of cycles that produced a carry-out.
module full_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   full_adder_if.slave  bus
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_w;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic [CNT_W-1:0] cnt_r;

   assign carry[0] = bus.cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a  (bus.a[i]),
         .b  (bus.b[i]),
         .ci (carry[i]),
         .s  (sum_w[i]),
         .co (carry[i+1])
      );
   end

   // Counter holds at all-ones rather than wrapping so a busy run stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r  <= '0;
         cout_r <= 1'b0;
         cnt_r  <= '0;
      end else begin
         sum_r  <= sum_w;
         cout_r <= carry[WIDTH];
         if (carry[WIDTH] && (cnt_r != {CNT_W{1'b1}}))
            cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign bus.sum       = sum_w;
   assign bus.cout      = carry[WIDTH];
   assign bus.sum_q     = sum_r;
   assign bus.cout_q    = cout_r;
   assign bus.carry_cnt = cnt_r;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: 1-bit, 4-bit and 3-bit-counter builds.
module tb_full_adder;

   logic clk;
   logic rst_n;

   full_adder_if #(.WIDTH(1), .CNT_W(16)) if1 ();
   full_adder_if #(.WIDTH(4), .CNT_W(16)) if4 ();
   full_adder_if #(.WIDTH(1), .CNT_W(3))  if3 ();

   full_adder #(.WIDTH(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   full_adder #(.WIDTH(4), .CNT_W(16)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   full_adder #(.WIDTH(1), .CNT_W(3))  dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

   int assert_cnt = 0;
   int fail_cnt   = 0;
   int cnt_model  = 0;
   logic [63:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assert_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input logic [63:0] e);
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input string tag, input logic [63:0] obs);
      if (exp_q.size() == 0) begin
         assert_cnt++;
         fail_cnt++;
         $display("[TB] FAIL %s: got %0h expected scoreboard entry", tag, obs);
      end else begin
         check_output(tag, obs, exp_q.pop_front());
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] v);
      if1.a   = v[2];
      if1.b   = v[1];
      if1.cin = v[0];
   endtask

   initial begin
      logic [1:0] e2;
      logic [4:0] e5;
      logic [3:0] va [3];
      logic [3:0] vb [3];
      logic       vc [3];

      va[0] = 4'hF; vb[0] = 4'h1; vc[0] = 1'b0;
      va[1] = 4'h5; vb[1] = 4'hA; vc[1] = 1'b1;
      va[2] = 4'h3; vb[2] = 4'h4; vc[2] = 1'b0;

      rst_n = 1'b0;
      apply_stimulus(3'b000);
      if4.a = '0; if4.b = '0; if4.cin = 1'b0;
      if3.a = '0; if3.b = '0; if3.cin = 1'b0;

      #3;
      sb_push(64'd0); sb_check("rst_comb", {if1.cout, if1.sum});
      sb_push(64'd0); sb_check("rst_reg",  {if1.cout_q, if1.sum_q});
      sb_push(64'd0); sb_check("rst_cnt",  if1.carry_cnt);

      @(negedge clk);
      rst_n = 1'b1;

      // One vector per clock: each is captured by exactly one rising edge.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v  = 3'(i);
         e2 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
         if (e2[1]) cnt_model++;
         apply_stimulus(v);
         sb_push(64'(e2));
         sb_push(64'(e2));
         sb_push(64'(cnt_model));
         #10;
         sb_check($sformatf("tt_comb_%0d", i), {if1.cout, if1.sum});
         sb_check($sformatf("tt_reg_%0d", i),  {if1.cout_q, if1.sum_q});
         sb_check($sformatf("tt_cnt_%0d", i),  if1.carry_cnt);
      end

      apply_stimulus(3'b000);
      sb_push(64'd0); sb_push(64'(cnt_model));
      #10;
      sb_check("idle_reg", {if1.cout_q, if1.sum_q});
      sb_check("idle_cnt", if1.carry_cnt);

      apply_stimulus(3'b110);
      cnt_model++;
      #1;
      sb_push(64'd0); sb_check("lat_before", {if1.cout_q, if1.sum_q});
      #5;
      sb_push(64'b10); sb_check("lat_after", {if1.cout_q, if1.sum_q});
      sb_push(64'd5);  sb_check("lat_cnt",   if1.carry_cnt);

      // Reset dropped between edges must clear state without a clock.
      rst_n = 1'b0;
      cnt_model = 0;
      #1;
      sb_push(64'd0);  sb_check("arst_reg",   {if1.cout_q, if1.sum_q});
      sb_push(64'd0);  sb_check("arst_cnt",   if1.carry_cnt);
      sb_push(64'b10); sb_check("arst_comb0", {if1.cout, if1.sum});
      apply_stimulus(3'b001);
      #1;
      sb_push(64'b01); sb_check("arst_comb1", {if1.cout, if1.sum});
      sb_push(64'd0);  sb_check("arst_hold",  {if1.cout_q, if1.sum_q});

      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 3; k++) begin
         if4.a   = va[k];
         if4.b   = vb[k];
         if4.cin = vc[k];
         e5 = 5'(va[k]) + 5'(vb[k]) + 5'(vc[k]);
         sb_push(64'(e5));
         sb_push(64'(e5));
         #10;
         sb_check($sformatf("w4_comb_%0d", k), {if4.cout, if4.sum});
         sb_check($sformatf("w4_reg_%0d", k),  {if4.cout_q, if4.sum_q});
      end

      sb_push(64'd0); sb_check("sat_start", if3.carry_cnt);
      if3.a = 1'b1; if3.b = 1'b1; if3.cin = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         sb_push(64'((k > 7) ? 7 : k));
         @(posedge clk);
         #1;
         sb_check($sformatf("sat_%0d", k), if3.carry_cnt);
      end

      @(negedge clk);
      if1.a = 1'bx; if1.b = 1'b0; if1.cin = 1'b0;
      #1;
      sb_push(64'(1'bx)); sb_check("x_sum", if1.sum);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
